// File: rtl/fibo_pkg.sv
// Shared types and default widths for the fibo Fibonacci engine.
package fibo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } fibo_state_e;

  localparam int FIBO_RES_W = 20;
  localparam int FIBO_IDX_W = 5;

endpackage

// File: rtl/fibo_if.sv
// Level start/finish handshake between a controller (master) and fibo (slave).
// The ovf signal exists only when FIBO_OVF_FLAG_EN is defined.
interface fibo_if
  import fibo_pkg::*;
#(
  parameter int RES_W = FIBO_RES_W,
  parameter int IDX_W = FIBO_IDX_W
) ();

  logic             start;
  logic [IDX_W-1:0] i;
  logic             finish;
  logic [RES_W-1:0] result;
`ifdef FIBO_OVF_FLAG_EN
  logic             ovf;
`endif

  modport master (
    output start,
    output i,
    input  finish,
    input  result
`ifdef FIBO_OVF_FLAG_EN
    , input ovf
`endif
  );

  modport slave (
    input  start,
    input  i,
    output finish,
    output result
`ifdef FIBO_OVF_FLAG_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/fibo_step.sv
// Fibonacci pair register (a=F(k), b=F(k+1)) with load and advance controls.
// Under FIBO_OVF_FLAG_EN it also exposes the carry out of the a+b adder.
module fibo_step
  import fibo_pkg::*;
#(
  parameter int RES_W = FIBO_RES_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             adv,
  output logic [RES_W-1:0] a
`ifdef FIBO_OVF_FLAG_EN
  , output logic           carry
`endif
);

  logic [RES_W-1:0] a_q, a_d;
  logic [RES_W-1:0] b_q, b_d;
  logic [RES_W-1:0] sum;

`ifdef FIBO_OVF_FLAG_EN
  logic [RES_W:0] sum_w;
  assign sum_w = {1'b0, a_q} + {1'b0, b_q};
  assign sum   = sum_w[RES_W-1:0];
  assign carry = sum_w[RES_W];
`else
  assign sum   = a_q + b_q;
`endif

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (load) begin
      a_d = '0;
      b_d = {{(RES_W-1){1'b0}}, 1'b1};
    end else if (adv) begin
      a_d = b_q;
      b_d = sum;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign a = a_q;

endmodule

// File: rtl/fibo.sv
// Sequential Fibonacci engine: IDLE/CALC/DONE FSM with a step counter around fibo_step.
// Optional ovf output enabled by defining FIBO_OVF_FLAG_EN.
module fibo
  import fibo_pkg::*;
#(
  parameter int RES_W = FIBO_RES_W,
  parameter int IDX_W = FIBO_IDX_W
) (
  input  logic clk,
  input  logic reset,
  fibo_if.slave bus
);

  fibo_state_e      state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [RES_W-1:0] result_q, result_d;
  logic [RES_W-1:0] a;
  logic             load;
  logic             adv;
`ifdef FIBO_OVF_FLAG_EN
  logic             ovf_q, ovf_d;
  logic             carry;
`endif

  fibo_step #(.RES_W(RES_W)) u_step (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .adv   (adv),
    .a     (a)
`ifdef FIBO_OVF_FLAG_EN
    , .carry (carry)
`endif
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    load     = 1'b0;
    adv      = 1'b0;
`ifdef FIBO_OVF_FLAG_EN
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          cnt_d   = bus.i;
          state_d = CALC;
`ifdef FIBO_OVF_FLAG_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      CALC: begin
        // cnt counts remaining adder steps; a already holds F(i) when it hits zero
        if (cnt_q == '0) begin
          result_d = a;
          state_d  = DONE;
        end else begin
          adv   = 1'b1;
          cnt_d = cnt_q - 1'b1;
`ifdef FIBO_OVF_FLAG_EN
          ovf_d = ovf_q | carry;
`endif
        end
      end
      DONE: begin
        if (!bus.start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
`ifdef FIBO_OVF_FLAG_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
`ifdef FIBO_OVF_FLAG_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.finish = (state_q == DONE);
  assign bus.result = result_q;
`ifdef FIBO_OVF_FLAG_EN
  assign bus.ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_fibo.sv
// Table-driven bench for fibo with a result/latency scoreboard queue.
module tb_fibo;

  localparam int RES_W = 20;
  localparam int IDX_W = 5;

  logic clk;
  logic reset;

  fibo_if #(.RES_W(RES_W), .IDX_W(IDX_W)) bus ();

  fibo #(.RES_W(RES_W), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int res;
    bit ovf;
    int lat;
  } exp_t;

  typedef struct {
    int idx;
    int exp_res;
    bit hold;
    bit chg;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   prev_res = 0;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Overflow flag model: any addition of truncated a+b reaching 2^RES_W.
  function automatic bit model_ovf(input int idx);
    longint a, b, s;
    bit o;
    a = 0; b = 1; o = 0;
    for (int k = 0; k < idx; k++) begin
      s = a + b;
      if (s >= (64'd1 << RES_W)) o = 1;
      a = b;
      b = s % (64'd1 << RES_W);
    end
    return o;
  endfunction

  task automatic do_txn(input int idx, input int exp_res, input bit hold, input bit chg);
    exp_t e;
    int   lat;
    @(negedge clk);
    bus.start = 1'b1;
    bus.i     = idx[IDX_W-1:0];
    e.res = exp_res;
    e.ovf = model_ovf(idx);
    e.lat = idx + 1;
    sb.push_back(e);
    @(posedge clk); #1;
    chk("result_hold_calc", bus.result, prev_res);
    chk("finish_low_calc", bus.finish, 0);
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
    if (chg) bus.i = 5'd3;
    @(posedge clk); #1;
    lat = 1;
    while (!bus.finish && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.finish) begin
      bad++; total++;
      $display("FAIL timeout idx=%0d actual=0 required=1", idx);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      chk("result", bus.result, e.res);
      chk("latency", lat, e.lat);
`ifdef FIBO_OVF_FLAG_EN
      chk("ovf", bus.ovf, e.ovf);
`endif
      prev_res = e.res;
    end
    if (hold) begin
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        chk("finish_held", bus.finish, 1);
        chk("result_steady", bus.result, exp_res);
      end
      @(negedge clk);
      bus.start = 1'b0;
    end
    @(posedge clk); #1;
    chk("finish_drop", bus.finish, 0);
    chk("result_after_drop", bus.result, exp_res);
  endtask

  vec_t vt[9];

  initial begin
    vt[0] = '{idx: 5,  exp_res: 5,      hold: 1, chg: 0};
    vt[1] = '{idx: 0,  exp_res: 0,      hold: 0, chg: 0};
    vt[2] = '{idx: 1,  exp_res: 1,      hold: 0, chg: 0};
    vt[3] = '{idx: 30, exp_res: 832040, hold: 0, chg: 0};
    vt[4] = '{idx: 31, exp_res: 297693, hold: 0, chg: 0};
    vt[5] = '{idx: 10, exp_res: 55,     hold: 0, chg: 1};
    vt[6] = '{idx: 2,  exp_res: 1,      hold: 1, chg: 0};
    vt[7] = '{idx: 12, exp_res: 144,    hold: 0, chg: 0};
    vt[8] = '{idx: 20, exp_res: 6765,   hold: 0, chg: 0};

    reset     = 1'b0;
    bus.start = 1'b0;
    bus.i     = '0;
    #12;
    chk("rst_finish", bus.finish, 0);
    chk("rst_result", bus.result, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("idle_finish", bus.finish, 0);
    end

    for (int v = 0; v < 9; v++)
      do_txn(vt[v].idx, vt[v].exp_res, vt[v].hold, vt[v].chg);

`ifdef FIBO_OVF_FLAG_EN
    chk("ovf_small_model", model_ovf(20), 0);
`endif

    // Reset aborts an in-flight i=20 computation.
    @(negedge clk);
    bus.start = 1'b1;
    bus.i     = 5'd20;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_finish", bus.finish, 0);
    chk("abort_result", bus.result, 0);
    @(negedge clk);
    reset = 1'b1;
    prev_res = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.finish) chk("abort_no_done", bus.finish, 0);
    end
    chk("abort_idle", bus.finish, 0);
    do_txn(7, 13, 0, 0);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
